// File: rtl/board_pkg.sv
// Shared constants for hx8k board I/O blocks.
// Debounce FSM encoding, default filter length and press counter width.
package board_pkg;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_PEND_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_PEND_LOW  = 2'd3;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 60000;
  localparam int          PRESS_W                 = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Resets both stages to 0; only the second stage is visible.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Debounced push-button reader: clean level, rise/fall strobes
// and a wrapping press count, all driven straight from flops.
module button_debounce
  import board_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               I,
  output logic               O,
  output logic               RISE,
  output logic               FALL,
  output logic [PRESS_W-1:0] PRESSES
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic          ONE  = (CYCLES == 1);

  logic               w_s2;
  logic [1:0]         r_state;
  logic [1:0]         w_state_n;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_n;
  logic               r_rise;
  logic               r_fall;
  logic               w_rise_n;
  logic               w_fall_n;
  logic [PRESS_W-1:0] r_presses;

  sync2 u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_d     (I),
    .o_q     (w_s2)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rise_n  = 1'b0;
    w_fall_n  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s2) begin
          if (ONE) begin
            w_state_n = ST_HIGH;
            w_rise_n  = 1'b1;
          end else begin
            w_state_n = ST_PEND_HIGH;
            w_cnt_n   = CW'(1);
          end
        end
      end
      ST_PEND_HIGH: begin
        if (!w_s2) begin
          w_state_n = ST_LOW;
          w_cnt_n   = '0;
        end else if (r_cnt == LAST) begin
          w_state_n = ST_HIGH;
          w_cnt_n   = '0;
          w_rise_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      ST_HIGH: begin
        if (!w_s2) begin
          if (ONE) begin
            w_state_n = ST_LOW;
            w_fall_n  = 1'b1;
          end else begin
            w_state_n = ST_PEND_LOW;
            w_cnt_n   = CW'(1);
          end
        end
      end
      ST_PEND_LOW: begin
        if (w_s2) begin
          w_state_n = ST_HIGH;
          w_cnt_n   = '0;
        end else if (r_cnt == LAST) begin
          w_state_n = ST_LOW;
          w_cnt_n   = '0;
          w_fall_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = ST_LOW;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_presses <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rise  <= w_rise_n;
      r_fall  <= w_fall_n;
      if (w_rise_n) r_presses <= r_presses + PRESS_W'(1);
    end
  end

  // Level is 1 in HIGH and PEND_LOW, i.e. the state MSB.
  assign O       = r_state[1];
  assign RISE    = r_rise;
  assign FALL    = r_fall;
  assign PRESSES = r_presses;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (CYCLES=4 and CYCLES=1 builds).
// Stimulus queues expected strobes; a negedge monitor pops and checks.
module tb_button_debounce;

  localparam int LAT = 4 + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ia    = 1'b0;
  logic       ib    = 1'b0;
  logic       oa, ra, fa;
  logic [7:0] pa;
  logic       ob, rb, fb;
  logic [7:0] pb;

  button_debounce #(.CYCLES(4)) dut_a (
    .CLK(clk), .RESETN(rst_n), .I(ia),
    .O(oa), .RISE(ra), .FALL(fa), .PRESSES(pa)
  );

  button_debounce #(.CYCLES(1)) dut_b (
    .CLK(clk), .RESETN(rst_n), .I(ib),
    .O(ob), .RISE(rb), .FALL(fb), .PRESSES(pb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_rise;
    int         at;
    logic [7:0] pr;
  } ev_t;

  ev_t        q[$];
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         n_rise   = 0;
  int         n_fall   = 0;
  int         exp_rise = 0;
  int         exp_fall = 0;
  logic [7:0] exp_pr   = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ra || fa) begin
      ev_t e;
      if (ra) n_rise++;
      if (fa) n_fall++;
      chk("strobe_exclusive", 32'(ra && fa), 0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", 32'(q.size() != 0), 1);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'(ra), 32'(e.is_rise));
        chk("strobe_cycle", cyc, e.at);
        chk("strobe_presses", 32'(pa), 32'(e.pr));
        chk("strobe_level", 32'(oa), 32'(e.is_rise));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk);
    ia = 1'b1;
    exp_pr = exp_pr + 8'd1;
    exp_rise++;
    q.push_back(ev_t'{1'b1, cyc + 1 + LAT, exp_pr});
  endtask

  task automatic release_a();
    @(negedge clk);
    ia = 1'b0;
    exp_fall++;
    q.push_back(ev_t'{1'b0, cyc + 1 + LAT, exp_pr});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_pr = 8'd0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    chk("por_O", 32'(oa), 0);
    chk("por_RISE", 32'(ra), 0);
    chk("por_PRESSES", 32'(pa), 0);
    rst_n = 1'b1;
    idle(10);
    chk("idle_O", 32'(oa), 0);

    // Clean press and release
    press();
    idle(10);
    chk("press_O", 32'(oa), 1);
    chk("press_PRESSES", 32'(pa), 1);
    release_a();
    idle(10);
    chk("release_O", 32'(oa), 0);

    // Asynchronous reset with pin high
    press();
    idle(10);
    chk("press2_PRESSES", 32'(pa), 2);
    @(negedge clk);
    #3 rst_n = 1'b0;
    exp_pr = 8'd0;
    #1;
    chk("async_rst_O", 32'(oa), 0);
    chk("async_rst_PRESSES", 32'(pa), 0);
    chk("async_rst_RISE", 32'(ra), 0);
    ia = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_O", 32'(oa), 0);
    chk("post_rst_PRESSES", 32'(pa), 0);

    // Bounce then hold high
    @(negedge clk); ia = 1'b1;
    @(negedge clk); ia = 1'b0;
    @(negedge clk); ia = 1'b1;
    @(negedge clk); ia = 1'b0;
    press();
    idle(12);
    chk("bounce_PRESSES", 32'(pa), 1);
    release_a();
    idle(12);

    // Reset while qualifying a press, pin kept high
    @(negedge clk);
    ia = 1'b1;
    idle(5);
    #1 rst_n = 1'b0;
    exp_pr = 8'd0;
    #1;
    chk("pend_rst_O", 32'(oa), 0);
    #1 rst_n = 1'b1;
    exp_pr = 8'd1;
    exp_rise++;
    q.push_back(ev_t'{1'b1, cyc + 1 + LAT, exp_pr});
    idle(12);
    chk("pend_resume_PRESSES", 32'(pa), 1);

    // 256 press/release pairs wrap the counter
    pulse_reset();
    ia = 1'b0;
    idle(4);
    for (int i = 0; i < 256; i++) begin
      press();
      idle(8);
      release_a();
      idle(8);
    end
    chk("wrap_PRESSES", 32'(pa), 32'(exp_pr));
    chk("wrap_PRESSES_zero", 32'(pa), 0);

    // CYCLES=1 build, single-cycle pulse
    @(negedge clk); ib = 1'b1;
    @(negedge clk); ib = 1'b0;
    chk("c1_k0_O", 32'(ob), 0);
    @(negedge clk);
    chk("c1_k1_O", 32'(ob), 0);
    @(negedge clk);
    chk("c1_k2_O", 32'(ob), 1);
    chk("c1_k2_RISE", 32'(rb), 1);
    chk("c1_k2_FALL", 32'(fb), 0);
    chk("c1_k2_PRESSES", 32'(pb), 1);
    @(negedge clk);
    chk("c1_k3_O", 32'(ob), 0);
    chk("c1_k3_RISE", 32'(rb), 0);
    chk("c1_k3_FALL", 32'(fb), 1);
    @(negedge clk);
    chk("c1_k4_FALL", 32'(fb), 0);
    chk("c1_k4_PRESSES", 32'(pb), 1);

    idle(4);
    chk("sb_outstanding", q.size(), 0);
    chk("total_rise", n_rise, exp_rise);
    chk("total_fall", n_fall, exp_fall);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
